init_deal_sequencer: RTL and testbench
======================================

// Module: init_deal_sequencer
// PURPOSE
//  Sequences the opening deal for one board: draws DEAL_CNT random cards from the shared deck
//  via DECK_DRAW messages, then hands the turn over with a STATE_TURN message.
//  Player 0 deals first. Player 1 waits for player 0's STATE_TURN, then deals.
//  Its ctrl_* outputs are muxed into the GameControl ctrl_* bus while busy=1.
//  Memory and interboard communication consume the messages.
// PARAMETERS
//  PLAYER     0   0: deal immediately on start_deal; 1: wait for peer STATE_TURN first
//  DEAL_CNT   14  cards drawn per board (1..15)
//  LFSR_SEED  7'h5A  nonzero reset value of the 7-bit LFSR
// PORTS
//  clk                 in   1    system clock
//  rst                 in   1    asynchronous, active-low reset
//  interboard_rst      in   1    synchronous clear, active-high; same effect as rst
//  start_deal          in   1    one-cycle pulse; honoured only in IDLE
//  send_ready          in   1    interboard TX can accept a message this cycle
//  interboard_en       in   1    incoming message strobe
//  interboard_msg_type in   4    incoming message type
//  available_card      in   106  bit i=1: deck card i still drawable
//  ctrl_en             out  1    one-cycle message strobe
//  ctrl_msg_type       out  4    5=DECK_DRAW, 6=STATE_TURN
//  ctrl_card           out  6    drawn card type = card_idx[6:1]; 0 for STATE_TURN
//  card_idx            out  7    deck index 0..105 of the current draw
//  transmit            out  1    high while this board owns the message bus (SEARCH..PASS)
//  busy                out  1    state != IDLE and state != DONE
//  deal_done           out  1    level, high in DONE
//  deal_err            out  1    sticky; deck was empty during a search
// BEHAVIOUR
//  Reset (rst=0 or interboard_rst=1):
//   - State=IDLE; all outputs 0; draw count=0; LFSR=LFSR_SEED.
//  LFSR:
//   - 7-bit Fibonacci LFSR, taps x^7+x^6+1, steps every cycle, never all-zero.
//  States:
//   - IDLE -> start_deal: PLAYER==0 ? SEARCH : WAIT_TURN.
//   - WAIT_TURN -> interboard_en && msg_type==6: SEARCH. Other messages are ignored.
//   - SEARCH:
//     - Entry cycle: ptr = LFSR>=106 ? LFSR-106 : LFSR.
//     - Each cycle: if available_card[ptr], latch card_idx=ptr and go to ISSUE.
//       Otherwise ptr = (ptr==105) ? 0 : ptr+1.
//     - After 106 consecutive misses: set deal_err and go to DONE; no message is sent.
//     - Worst case 106 cycles.
//   - ISSUE:
//     - Wait for send_ready=1.
//     - In that cycle: ctrl_en=1, msg_type=5, ctrl_card=card_idx[6:1]; then go to WAIT_ACK.
//     - ctrl_en is never asserted while send_ready=0.
//   - WAIT_ACK:
//     - Wait until available_card[card_idx]==0 and send_ready==1.
//     - Then count+1. count==DEAL_CNT ? PASS : SEARCH (new random ptr).
//   - PASS: wait for send_ready; ctrl_en=1, msg_type=6, ctrl_card=0 for one cycle; go to DONE.
//   - DONE: hold until rst or interboard_rst. start_deal is ignored.
//  Output rules:
//   - ctrl_msg_type, ctrl_card and card_idx are registered. They hold their last values while
//     ctrl_en=0 and are valid only with ctrl_en.
//   - ctrl_en is registered: one cycle high per message, never high on two consecutive cycles.
//  Boundaries:
//   - Reset mid-operation aborts immediately; no further ctrl_en is issued.
//   - available_card may change during SEARCH; each cycle samples the current value.
//   - start_deal outside IDLE is ignored.
//   - If interboard_en (STATE_TURN) arrives in IDLE for PLAYER=1 before start_deal, it is lost.
//     The top level must issue start_deal first.
// TESTING
//  1. PLAYER=0, all 106 available; memory clears bit 2 cycles after each ctrl_en; send_ready=1
//     -> 14 DECK_DRAW strobes with distinct card_idx, then one STATE_TURN, then deal_done=1.
//  2. PLAYER=1, start_deal, no peer message for 500 cycles -> zero ctrl_en, busy=1;
//     then inject msg 6 -> first DECK_DRAW within 108 cycles.
//  3. Only bit 105 available, seed forcing ptr=0 -> SEARCH wraps, card_idx=105 found after
//     106 cycles, ctrl_card=52.
//  4. available_card all 0 -> no ctrl_en; deal_err=1 and deal_done=1 after 106 SEARCH cycles.
//  5. Hold send_ready=0 for 20 cycles in ISSUE -> ctrl_en stays 0; strobe on the first
//     ready cycle only.
//  6. Assert rst low after the 5th draw, release, start again -> count restarts,
//     exactly 14 further draws.

Source files
------------

// File: rtl/init_deal_sequencer.sv
// -----------------------------------------------------------------------------
// init_deal_sequencer
// Sequences the opening deal for one board. Draws DEAL_CNT random cards from
// the shared deck (DECK_DRAW, type 5), then hands the turn to the peer board
// (STATE_TURN, type 6). Player 0 deals on start_deal; player 1 first waits for
// the peer's STATE_TURN.
//
// Ports
//   clk, rst (async, active low), interboard_rst (sync, active high)
//   start_deal          : one-cycle start pulse, honoured only in IDLE
//   send_ready          : interboard TX can take a message this cycle
//   interboard_en/_msg_type : incoming message strobe and type
//   available_card[105:0]   : deck availability, bit i = card i drawable
//   ctrl_en/_msg_type/_card : registered outgoing message
//   card_idx            : deck index of the current draw
//   transmit            : board owns the message bus (SEARCH..PASS)
//   busy, deal_done     : activity / completion levels
//   deal_err            : sticky, deck was empty during a search
// -----------------------------------------------------------------------------
module init_deal_sequencer #(
    parameter int         PLAYER    = 0,
    parameter int         DEAL_CNT  = 14,
    parameter logic [6:0] LFSR_SEED = 7'h5A
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         interboard_rst,
    input  logic         start_deal,
    input  logic         send_ready,
    input  logic         interboard_en,
    input  logic [3:0]   interboard_msg_type,
    input  logic [105:0] available_card,
    output logic         ctrl_en,
    output logic [3:0]   ctrl_msg_type,
    output logic [5:0]   ctrl_card,
    output logic [6:0]   card_idx,
    output logic         transmit,
    output logic         busy,
    output logic         deal_done,
    output logic         deal_err
);

    localparam logic [3:0] LP_DEAL_CNT   = DEAL_CNT[3:0];
    localparam logic [3:0] LP_DECK_DRAW  = 4'd5;
    localparam logic [3:0] LP_STATE_TURN = 4'd6;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_TURN, S_SEARCH, S_ISSUE, S_WAIT_ACK, S_PASS, S_DONE
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [6:0] r_lfsr;
    logic [6:0] r_ptr,   w_ptr_nxt;
    logic       r_first, w_first_nxt;   // first SEARCH cycle: seed ptr from LFSR
    logic [6:0] r_miss,  w_miss_nxt;
    logic [3:0] r_cnt,   w_cnt_nxt;
    logic [6:0] r_idx,   w_idx_nxt;
    logic       r_en,    w_en_nxt;
    logic [3:0] r_type,  w_type_nxt;
    logic [5:0] r_card,  w_card_nxt;
    logic       r_err,   w_err_nxt;

    logic [6:0] w_lfsr_mod, w_ptr, w_ptr_inc;
    logic [3:0] w_cnt_inc;

    // LFSR values 106..127 fold back onto the deck range.
    assign w_lfsr_mod = (r_lfsr >= 7'd106) ? (r_lfsr - 7'd106) : r_lfsr;
    assign w_ptr      = r_first ? w_lfsr_mod : r_ptr;
    assign w_ptr_inc  = (w_ptr == 7'd105) ? 7'd0 : (w_ptr + 7'd1);
    assign w_cnt_inc  = r_cnt + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_first_nxt = 1'b0;
        w_miss_nxt  = r_miss;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_en_nxt    = 1'b0;
        w_type_nxt  = r_type;
        w_card_nxt  = r_card;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (start_deal) begin
                    if (PLAYER == 0) begin
                        w_state_nxt = S_SEARCH;
                        w_first_nxt = 1'b1;
                        w_miss_nxt  = 7'd0;
                    end else begin
                        w_state_nxt = S_WAIT_TURN;
                    end
                end
            end
            S_WAIT_TURN: begin
                if (interboard_en && interboard_msg_type == LP_STATE_TURN) begin
                    w_state_nxt = S_SEARCH;
                    w_first_nxt = 1'b1;
                    w_miss_nxt  = 7'd0;
                end
            end
            S_SEARCH: begin
                if (available_card[w_ptr]) begin
                    w_idx_nxt   = w_ptr;
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_ptr_nxt = w_ptr_inc;
                    // r_miss counts earlier misses; this is the 106th.
                    if (r_miss == 7'd105) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_miss_nxt = r_miss + 7'd1;
                    end
                end
            end
            S_ISSUE: begin
                if (send_ready) begin
                    w_en_nxt    = 1'b1;
                    w_type_nxt  = LP_DECK_DRAW;
                    w_card_nxt  = r_idx[6:1];
                    w_state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // Memory acknowledges the draw by clearing the card's bit.
                if (!available_card[r_idx] && send_ready) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == LP_DEAL_CNT) begin
                        w_state_nxt = S_PASS;
                    end else begin
                        w_state_nxt = S_SEARCH;
                        w_first_nxt = 1'b1;
                        w_miss_nxt  = 7'd0;
                    end
                end
            end
            S_PASS: begin
                if (send_ready) begin
                    w_en_nxt    = 1'b1;
                    w_type_nxt  = LP_STATE_TURN;
                    w_card_nxt  = 6'd0;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_lfsr  <= LFSR_SEED;
            r_ptr   <= 7'd0;
            r_first <= 1'b0;
            r_miss  <= 7'd0;
            r_cnt   <= 4'd0;
            r_idx   <= 7'd0;
            r_en    <= 1'b0;
            r_type  <= 4'd0;
            r_card  <= 6'd0;
            r_err   <= 1'b0;
        end else if (interboard_rst) begin
            r_state <= S_IDLE;
            r_lfsr  <= LFSR_SEED;
            r_ptr   <= 7'd0;
            r_first <= 1'b0;
            r_miss  <= 7'd0;
            r_cnt   <= 4'd0;
            r_idx   <= 7'd0;
            r_en    <= 1'b0;
            r_type  <= 4'd0;
            r_card  <= 6'd0;
            r_err   <= 1'b0;
        end else begin
            // x^7 + x^6 + 1, maximal length: never reaches zero from a nonzero seed.
            r_lfsr  <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_first <= w_first_nxt;
            r_miss  <= w_miss_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_en    <= w_en_nxt;
            r_type  <= w_type_nxt;
            r_card  <= w_card_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign ctrl_en       = r_en;
    assign ctrl_msg_type = r_type;
    assign ctrl_card     = r_card;
    assign card_idx      = r_idx;
    assign deal_err      = r_err;
    assign deal_done     = (r_state == S_DONE);
    assign busy          = (r_state != S_IDLE) && (r_state != S_DONE);
    assign transmit      = (r_state == S_SEARCH) || (r_state == S_ISSUE) ||
                           (r_state == S_WAIT_ACK) || (r_state == S_PASS);

endmodule

// File: tb/tb_init_deal_sequencer.sv
module tb_init_deal_sequencer;
    localparam logic [6:0] SEED = 7'h5A;

    logic         clk = 1'b0;
    logic         rst = 1'b0, ib_rst = 1'b0, sr = 1'b0;
    logic         sd0 = 1'b0, sd1 = 1'b0, ie0 = 1'b0, ie1 = 1'b0;
    logic [3:0]   mt = 4'd0;
    logic [105:0] avail = '1;

    logic       en0, tx0, busy0, done0, err0, en1, tx1, busy1, done1, err1;
    logic [3:0] type0, type1;
    logic [5:0] card0, card1;
    logic [6:0] idx0, idx1;

    always #5 clk = ~clk;

    init_deal_sequencer #(.PLAYER(0), .DEAL_CNT(14), .LFSR_SEED(SEED)) u0 (
        .clk(clk), .rst(rst), .interboard_rst(ib_rst), .start_deal(sd0), .send_ready(sr),
        .interboard_en(ie0), .interboard_msg_type(mt), .available_card(avail),
        .ctrl_en(en0), .ctrl_msg_type(type0), .ctrl_card(card0), .card_idx(idx0),
        .transmit(tx0), .busy(busy0), .deal_done(done0), .deal_err(err0));

    init_deal_sequencer #(.PLAYER(1), .DEAL_CNT(14), .LFSR_SEED(SEED)) u1 (
        .clk(clk), .rst(rst), .interboard_rst(ib_rst), .start_deal(sd1), .send_ready(sr),
        .interboard_en(ie1), .interboard_msg_type(mt), .available_card(avail),
        .ctrl_en(en1), .ctrl_msg_type(type1), .ctrl_card(card1), .card_idx(idx1),
        .transmit(tx1), .busy(busy1), .deal_done(done1), .deal_err(err1));

    typedef struct {
        logic [3:0] t;
        logic [5:0] card;
        logic [6:0] idx;
        logic       av;
    } obs_t;

    obs_t       obs_q[$];
    logic [3:0] exp_q[$];
    int n_chk = 0, n_fail = 0;
    int u1_en = 0, v_consec = 0, v_ready = 0;
    logic prev_en = 1'b0;
    logic auto_clr = 1'b0;
    logic clr1_v = 1'b0, clr2_v = 1'b0;
    logic [6:0] clr1_i = '0, clr2_i = '0;
    logic [6:0] m_lfsr = SEED;

    function automatic logic [6:0] lstep(input logic [6:0] v);
        return {v[5:0], v[6] ^ v[5]};
    endfunction

    // One clock: sample #1 after the edge, record u0 strobes, emulate memory
    // clearing a drawn card two cycles after its DECK_DRAW.
    task automatic tick;
        obs_t o;
        @(posedge clk);
        #1;
        if (!rst || ib_rst) m_lfsr = SEED; else m_lfsr = lstep(m_lfsr);
        if (en0) begin
            o.t = type0; o.card = card0; o.idx = idx0; o.av = avail[idx0];
            obs_q.push_back(o);
            if (prev_en) v_consec++;
            if (!sr) v_ready++;          // sr still holds its value from the edge
        end
        prev_en = en0;
        if (en1) u1_en++;
        if (clr2_v) avail[clr2_i] = 1'b0;
        clr2_v = clr1_v; clr2_i = clr1_i;
        clr1_v = auto_clr && en0 && (type0 == 4'd5);
        clr1_i = idx0;
    endtask

    task automatic do_reset;
        rst = 1'b0; ib_rst = 1'b0; sd0 = 1'b0; sd1 = 1'b0; ie0 = 1'b0; ie1 = 1'b0;
        repeat (2) tick;
        rst = 1'b1;
        obs_q.delete(); exp_q.delete();
        prev_en = 1'b0; v_consec = 0; v_ready = 0; u1_en = 0;
        clr1_v = 1'b0; clr2_v = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) tick;
        n_chk++;
        if ({en0, type0, card0, idx0, tx0, busy0, done0, err0} !== '0) begin
            n_fail++; $display("FAIL reset_u0: got %h want 0", {en0, type0, card0, idx0, tx0, busy0, done0, err0});
        end
        n_chk++;
        if ({en1, type1, card1, idx1, tx1, busy1, done1, err1} !== '0) begin
            n_fail++; $display("FAIL reset_u1: got %h want 0", {en1, type1, card1, idx1, tx1, busy1, done1, err1});
        end
        rst = 1'b1;
    endtask

    task automatic test_deal;
        int n; obs_t o; logic [3:0] e; logic [105:0] seen;
        do_reset; avail = '1; sr = 1'b1; auto_clr = 1'b1;
        for (int i = 0; i < 14; i++) exp_q.push_back(4'd5);
        exp_q.push_back(4'd6);
        sd0 = 1'b1; tick; sd0 = 1'b0;
        n = 0;
        while (!done0 && n < 3000) begin tick; n++; end
        n_chk++;
        if (!(done0 === 1'b1 && err0 === 1'b0 && busy0 === 1'b0)) begin
            n_fail++; $display("FAIL deal_end: done=%b err=%b busy=%b want 1 0 0", done0, err0, busy0);
        end
        n_chk++;
        if (obs_q.size() != 15) begin
            n_fail++; $display("FAIL deal_msgs: got %0d want 15", obs_q.size());
        end
        seen = '0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_chk++;
            if (o.t !== e) begin n_fail++; $display("FAIL deal_type: got %0d want %0d", o.t, e); end
            n_chk++;
            if (e == 4'd5) begin
                if (o.card !== o.idx[6:1] || o.av !== 1'b1 || seen[o.idx] !== 1'b0) begin
                    n_fail++; $display("FAIL deal_draw: idx=%0d card=%0d av=%b dup=%b want card=%0d av=1 dup=0",
                                       o.idx, o.card, o.av, seen[o.idx], o.idx[6:1]);
                end
                seen[o.idx] = 1'b1;
            end else if (o.card !== 6'd0) begin
                n_fail++; $display("FAIL deal_pass_card: got %0d want 0", o.card);
            end
        end
        n_chk++;
        if (v_consec != 0 || v_ready != 0) begin
            n_fail++; $display("FAIL deal_strobe: consecutive=%0d unready=%0d want 0 0", v_consec, v_ready);
        end
    endtask

    task automatic test_wait_turn;
        int n;
        do_reset; avail = '1; sr = 1'b1; auto_clr = 1'b0;
        ie1 = 1'b1; mt = 4'd6; tick; ie1 = 1'b0;     // arrives in IDLE: lost
        sd1 = 1'b1; tick; sd1 = 1'b0;
        repeat (500) tick;
        n_chk++;
        if (u1_en != 0 || busy1 !== 1'b1 || tx1 !== 1'b0) begin
            n_fail++; $display("FAIL wait_idle: en=%0d busy=%b tx=%b want 0 1 0", u1_en, busy1, tx1);
        end
        ie1 = 1'b1; mt = 4'd5; tick; ie1 = 1'b0;
        repeat (5) tick;
        n_chk++;
        if (tx1 !== 1'b0 || u1_en != 0) begin
            n_fail++; $display("FAIL wait_other_msg: tx=%b en=%0d want 0 0", tx1, u1_en);
        end
        ie1 = 1'b1; mt = 4'd6; tick; ie1 = 1'b0;
        n = 0;
        while (!en1 && n < 200) begin tick; n++; end
        n_chk++;
        if (en1 !== 1'b1 || n > 108) begin
            n_fail++; $display("FAIL wait_first_draw: en=%b latency=%0d want 1 <=108", en1, n);
        end
        n_chk++;
        if (type1 !== 4'd5 || card1 !== idx1[6:1]) begin
            n_fail++; $display("FAIL wait_draw_msg: type=%0d card=%0d want 5 %0d", type1, card1, idx1[6:1]);
        end
    endtask

    task automatic test_wrap;
        int n;
        do_reset; avail = '0; avail[105] = 1'b1; sr = 1'b1; auto_clr = 1'b0;
        // Start so the entry-cycle LFSR is 106, which folds to ptr 0.
        n = 0;
        while (lstep(m_lfsr) != 7'd106 && n < 200) begin tick; n++; end
        sd0 = 1'b1; tick; sd0 = 1'b0;
        n = 0;
        while (!en0 && n < 300) begin tick; n++; end
        // 106 SEARCH cycles, one ISSUE cycle, then the strobe.
        n_chk++;
        if (n != 107) begin n_fail++; $display("FAIL wrap_latency: got %0d want 107", n); end
        n_chk++;
        if (idx0 !== 7'd105 || card0 !== 6'd52 || type0 !== 4'd5) begin
            n_fail++; $display("FAIL wrap_card: idx=%0d card=%0d type=%0d want 105 52 5", idx0, card0, type0);
        end
    endtask

    task automatic test_empty;
        int n;
        do_reset; avail = '0; sr = 1'b1; auto_clr = 1'b0;
        sd0 = 1'b1; tick; sd0 = 1'b0;
        n = 0;
        while (!done0 && n < 300) begin tick; n++; end
        n_chk++;
        if (n != 106) begin n_fail++; $display("FAIL empty_latency: got %0d want 106", n); end
        n_chk++;
        if (err0 !== 1'b1 || done0 !== 1'b1 || busy0 !== 1'b0 || tx0 !== 1'b0 || obs_q.size() != 0) begin
            n_fail++; $display("FAIL empty_flags: err=%b done=%b busy=%b tx=%b msgs=%0d want 1 1 0 0 0",
                               err0, done0, busy0, tx0, obs_q.size());
        end
        sd0 = 1'b1; tick; sd0 = 1'b0;
        repeat (5) tick;
        n_chk++;
        if (done0 !== 1'b1 || err0 !== 1'b1 || tx0 !== 1'b0 || obs_q.size() != 0) begin
            n_fail++; $display("FAIL done_hold: done=%b err=%b tx=%b msgs=%0d want 1 1 0 0", done0, err0, tx0, obs_q.size());
        end
        ib_rst = 1'b1; tick; ib_rst = 1'b0;
        n_chk++;
        if ({err0, done0, busy0} !== 3'b000) begin
            n_fail++; $display("FAIL ib_rst_clear: got %b want 000", {err0, done0, busy0});
        end
    endtask

    task automatic test_ready_hold;
        do_reset; avail = '1; sr = 1'b0; auto_clr = 1'b1;
        sd0 = 1'b1; tick; sd0 = 1'b0;
        repeat (20) tick;
        n_chk++;
        if (obs_q.size() != 0 || tx0 !== 1'b1 || busy0 !== 1'b1) begin
            n_fail++; $display("FAIL hold_noready: msgs=%0d tx=%b busy=%b want 0 1 1", obs_q.size(), tx0, busy0);
        end
        sr = 1'b1; tick;
        n_chk++;
        if (en0 !== 1'b1 || type0 !== 4'd5) begin
            n_fail++; $display("FAIL hold_first_ready: en=%b type=%0d want 1 5", en0, type0);
        end
        sr = 1'b0; tick;
        n_chk++;
        if (en0 !== 1'b0) begin n_fail++; $display("FAIL hold_single: en=%b want 0", en0); end
        repeat (5) tick;
        n_chk++;
        if (obs_q.size() != 1 || v_ready != 0) begin
            n_fail++; $display("FAIL hold_count: msgs=%0d unready=%0d want 1 0", obs_q.size(), v_ready);
        end
    endtask

    task automatic test_reset_mid;
        int n; obs_t o; logic [3:0] e; logic [105:0] seen;
        do_reset; avail = '1; sr = 1'b1; auto_clr = 1'b1;
        sd0 = 1'b1; tick; sd0 = 1'b0;
        n = 0;
        while (obs_q.size() < 5 && n < 1000) begin tick; n++; end
        n_chk++;
        if (obs_q.size() != 5) begin n_fail++; $display("FAIL mid_five: got %0d want 5", obs_q.size()); end
        rst = 1'b0; #1;
        n_chk++;
        if ({en0, busy0, tx0, type0, idx0} !== '0) begin
            n_fail++; $display("FAIL mid_abort: got %h want 0", {en0, busy0, tx0, type0, idx0});
        end
        repeat (3) tick;
        n_chk++;
        if (obs_q.size() != 5) begin n_fail++; $display("FAIL mid_no_more: got %0d want 5", obs_q.size()); end
        rst = 1'b1; avail = '1; obs_q.delete(); clr1_v = 1'b0; clr2_v = 1'b0;
        for (int i = 0; i < 14; i++) exp_q.push_back(4'd5);
        exp_q.push_back(4'd6);
        sd0 = 1'b1; tick; sd0 = 1'b0;
        n = 0;
        while (!done0 && n < 3000) begin tick; n++; end
        n_chk++;
        if (obs_q.size() != 15 || done0 !== 1'b1) begin
            n_fail++; $display("FAIL mid_restart: msgs=%0d done=%b want 15 1", obs_q.size(), done0);
        end
        seen = '0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_chk++;
            if (o.t !== e || (e == 4'd5 && seen[o.idx] !== 1'b0)) begin
                n_fail++; $display("FAIL mid_msg: type=%0d idx=%0d dup=%b want type %0d dup 0", o.t, o.idx, seen[o.idx], e);
            end
            if (e == 4'd5) seen[o.idx] = 1'b1;
        end
        n_chk++;
        if (v_consec != 0 || v_ready != 0) begin
            n_fail++; $display("FAIL mid_strobe: consecutive=%0d unready=%0d want 0 0", v_consec, v_ready);
        end
    endtask

    initial begin
        test_reset;
        test_deal;
        test_wait_turn;
        test_wrap;
        test_empty;
        test_ready_hold;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
